// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain/packer path.
// Holds the default word width, a word typedef and the packer phase encoding.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int PACK_DEF       = 2;
    localparam int TIMEOUT_DEF    = 64;

    typedef logic [FIFO_WIDTH_DEF-1:0] word_t;

    // Coarse packer phases, handy when probing the assembly logic in a waveform.
    typedef enum logic [1:0] {
        PK_IDLE     = 2'd0,
        PK_ASSEMBLE = 2'd1,
        PK_STALL    = 2'd2,
        PK_FLUSH    = 2'd3
    } pack_state_t;

endpackage

// File: rtl/pack_out_slot.sv
// One-entry valid/ready output register for the word packer.
// Holds data/keep stable while the consumer back-pressures; load is only
// asserted by the parent when load_ok is high, so nothing is ever overwritten.
module pack_out_slot #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_valid,
    output logic              load_ok
);

    logic [DATA_W-1:0] data_reg;
    logic [KEEP_W-1:0] keep_reg;
    logic              valid_reg;

    // Slot can take a new beat when empty or when the current one leaves this edge.
    assign load_ok   = !valid_reg || out_ready;
    assign out_data  = data_reg;
    assign out_keep  = keep_reg;
    assign out_valid = valid_reg;

    // Register the beat; a same-edge reload keeps valid high through a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= '0;
            keep_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            keep_reg  <= load_keep;
            valid_reg <= 1'b1;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Drain stage for the synchronous FIFO: pops words (1-cycle read latency) and
// packs PACK consecutive words into one wide valid/ready beat, word 0 in LSBs.
// Partial beats leave through the flush pulse; with PACKER_TIMEOUT_FLUSH_EN
// defined an idle timer also raises an internal flush after TIMEOUT_CYCLES.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH     = FIFO_WIDTH_DEF,
    parameter int PACK           = PACK_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FIFO_WIDTH-1:0]      fifo_dout,
    input  logic                       fifo_empty,
    input  logic                       fifo_udf,
    output logic                       fifo_rd_en,
    input  logic                       flush,
    output logic [FIFO_WIDTH*PACK-1:0] out_data,
    output logic [PACK-1:0]            out_keep,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       err
);

    localparam int BEAT_W = FIFO_WIDTH * PACK;
    localparam int CNT_W  = $clog2(PACK + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK - 1);

    logic [FIFO_WIDTH-1:0] asm_reg [PACK];
    logic [CNT_W-1:0]      count_reg;
    logic                  inflight_reg;
    logic                  flush_pend_reg;
    logic                  err_reg;

    logic                  load_ok;
    logic                  complete;
    logic                  drain_held;
    logic                  slot_load;
    logic                  flush_done;
    logic                  timeout_flush;
    logic [CNT_W:0]        count_sum;
    logic [BEAT_W-1:0]     full_data;
    logic [BEAT_W-1:0]     part_data;
    logic [PACK-1:0]       part_keep;
    logic [BEAT_W-1:0]     slot_data;
    logic [PACK-1:0]       slot_keep;

    // Incoming word lands in the last lane: the beat is complete this edge.
    assign complete = inflight_reg && (count_reg == CNT_LAST);

    // Held lanes leave when nothing is in flight and either the beat is a stalled
    // full one or a flush is pending; the slot must be able to take it.
    assign drain_held = !inflight_reg && (count_reg != '0) && load_ok &&
                        ((count_reg == CNT_FULL) || flush_pend_reg);

    assign slot_load = (complete && load_ok) || drain_held;

    // Flush finishes once no read is outstanding and the held lanes are gone or go now.
    assign flush_done = flush_pend_reg && !inflight_reg &&
                        ((count_reg == '0) || load_ok);

    // Lane views: a completing beat takes its top lane straight from the FIFO;
    // a held beat masks off lanes that were never filled.
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
        assign part_keep[gi] = (CNT_W'(gi) < count_reg);
        assign part_data[gi*FIFO_WIDTH +: FIFO_WIDTH] =
            part_keep[gi] ? asm_reg[gi] : '0;
        if (gi == PACK - 1) begin : g_top
            assign full_data[gi*FIFO_WIDTH +: FIFO_WIDTH] = fifo_dout;
        end else begin : g_low
            assign full_data[gi*FIFO_WIDTH +: FIFO_WIDTH] = asm_reg[gi];
        end

        // Capture the returning FIFO word into the lane selected by count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                asm_reg[gi] <= '0;
            end else if (inflight_reg && (count_reg == CNT_W'(gi))) begin
                asm_reg[gi] <= fifo_dout;
            end
        end
    end

    assign slot_data = complete ? full_data : part_data;
    assign slot_keep = complete ? '1 : part_keep;

    // Outstanding words never exceed free lanes; the extra term keeps 1 word/cycle
    // flowing when the completing beat can leave this same edge.
    assign count_sum  = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    assign fifo_rd_en = !rst && !fifo_empty && !flush_pend_reg &&
                        ((count_sum < (CNT_W + 1)'(PACK)) ||
                         (inflight_reg && (count_reg == CNT_LAST) && load_ok));

    assign err = err_reg;

`ifdef PACKER_TIMEOUT_FLUSH_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_reg;
    logic              idle_cond;

    assign idle_cond     = (count_reg != '0) && !inflight_reg && fifo_empty;
    assign timeout_flush = idle_cond && (idle_reg == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Count idle cycles with a partial beat parked; any capture breaks the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_reg <= '0;
        end else if (!idle_cond || timeout_flush) begin
            idle_reg <= '0;
        end else begin
            idle_reg <= idle_reg + 1'b1;
        end
    end
`else
    assign timeout_flush = 1'b0;
`endif

    // Lane count, read tracking, flush request and sticky underflow error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg      <= '0;
            inflight_reg   <= 1'b0;
            flush_pend_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            inflight_reg <= fifo_rd_en;

            if (fifo_udf) begin
                err_reg <= 1'b1;
            end

            if (inflight_reg) begin
                if (complete) begin
                    count_reg <= load_ok ? '0 : CNT_FULL;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end else if (slot_load) begin
                count_reg <= '0;
            end

            if (flush || timeout_flush) begin
                flush_pend_reg <= 1'b1;
            end else if (flush_done) begin
                flush_pend_reg <= 1'b0;
            end
        end
    end

    pack_out_slot #(
        .DATA_W (BEAT_W),
        .KEEP_W (PACK)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_load),
        .load_data (slot_data),
        .load_keep (slot_keep),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .load_ok   (load_ok)
    );

endmodule
